// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Encodings outside even/odd fall back to no parity bit.
    function automatic logic parity_en(input int mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/fifo_uart_if.sv
// FIFO read port plus serial/status outputs of the UART drain stage.
interface fifo_uart_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) ();
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_data;
    logic               fifo_rd_ena;
    logic               tx;
    logic               busy;
    logic [COUNT_W-1:0] frame_count;

    modport master (
        input  fifo_empty, fifo_data,
        output fifo_rd_ena, tx, busy, frame_count
    );

    modport slave (
        output fifo_empty, fifo_data,
        input  fifo_rd_ena, tx, busy, frame_count
    );
endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses o_bit_done on the last count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_bit_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_done = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the byte FIFO and serializes them: start, data LSB first,
// optional parity, one stop bit.
//   state      | meaning
//   ST_IDLE    | line high, waiting for FIFO non-empty
//   ST_FETCH   | one-cycle read strobe to the FIFO
//   ST_LATCH   | FIFO data valid, load shifter and parity
//   ST_START   | start bit (low)
//   ST_DATA    | WIDTH data bits, LSB first
//   ST_PARITY  | parity bit
//   ST_STOP    | stop bit (high), frame counted on its last cycle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int COUNT_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    fifo_uart_if.master bus
);
    localparam int BIDX_W = $clog2(WIDTH + 1);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(WIDTH - 1);
    localparam logic PAR_ON  = parity_en(PARITY);
    localparam logic PAR_INV = (PARITY == PAR_ODD);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [BIDX_W-1:0]  r_bit_idx, w_bit_idx_nxt;
    logic               r_par, w_par_nxt;
    logic [COUNT_W-1:0] r_count, w_count_nxt;
    logic               r_tx, w_tx_nxt;
    logic               r_rd_ena, w_rd_ena_nxt;
    logic               w_bit_done;
    logic               w_restart;

    assign w_restart = (w_state_nxt != r_state);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_restart  (w_restart),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_count   <= '0;
            r_tx      <= 1'b1;
            r_rd_ena  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_par     <= w_par_nxt;
            r_count   <= w_count_nxt;
            r_tx      <= w_tx_nxt;
            r_rd_ena  <= w_rd_ena_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_par_nxt     = r_par;
        w_count_nxt   = r_count;
        w_tx_nxt      = 1'b1;
        w_rd_ena_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!bus.fifo_empty) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_shift_nxt   = bus.fifo_data;
                w_par_nxt     = (^bus.fifo_data) ^ PAR_INV;
                w_bit_idx_nxt = '0;
                w_state_nxt   = ST_START;
            end
            ST_START: begin
                if (w_bit_done) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = PAR_ON ? ST_PARITY : ST_STOP;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_count_nxt = r_count + 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        w_rd_ena_nxt = (w_state_nxt == ST_FETCH);
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    assign bus.tx          = r_tx;
    assign bus.fifo_rd_ena = r_rd_ena;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_count = r_count;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitters (no/even/odd parity) fed by small FIFO models.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_uart_if #(.WIDTH(8), .COUNT_W(4))  if_a ();
    fifo_uart_if #(.WIDTH(8), .COUNT_W(16)) if_b ();
    fifo_uart_if #(.WIDTH(8), .COUNT_W(16)) if_c ();

    logic       r_empty_a, r_empty_b, r_empty_c;
    logic [7:0] r_data_a, r_data_b, r_data_c;
    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    logic [7:0] fq_c[$];

    assign if_a.fifo_empty = r_empty_a;
    assign if_a.fifo_data  = r_data_a;
    assign if_b.fifo_empty = r_empty_b;
    assign if_b.fifo_data  = r_data_b;
    assign if_c.fifo_empty = r_empty_c;
    assign if_c.fifo_data  = r_data_c;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .COUNT_W(4)) u_dut_a (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if_a.master));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .COUNT_W(16)) u_dut_b (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if_b.master));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .COUNT_W(16)) u_dut_c (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if_c.master));

    wire [2:0] w_tx   = {if_c.tx, if_b.tx, if_a.tx};
    wire [2:0] w_rd   = {if_c.fifo_rd_ena, if_b.fifo_rd_ena, if_a.fifo_rd_ena};
    wire [2:0] w_busy = {if_c.busy, if_b.busy, if_a.busy};

    int n_vec = 0;
    int n_err = 0;
    int n_pulse[3];

    // FIFO models: data appears the cycle after a read strobe.
    initial begin
        r_empty_a = 1'b1; r_empty_b = 1'b1; r_empty_c = 1'b1;
        r_data_a  = '0;   r_data_b  = '0;   r_data_c  = '0;
        forever begin
            @(negedge clk);
            if (w_rd[0] === 1'b1 && fq_a.size() > 0) r_data_a = fq_a.pop_front();
            if (w_rd[1] === 1'b1 && fq_b.size() > 0) r_data_b = fq_b.pop_front();
            if (w_rd[2] === 1'b1 && fq_c.size() > 0) r_data_c = fq_c.pop_front();
            r_empty_a = (fq_a.size() == 0);
            r_empty_b = (fq_b.size() == 0);
            r_empty_c = (fq_c.size() == 0);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) n_pulse[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) if (w_rd[i] === 1'b1) n_pulse[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // seq[k] is the k-th line bit of the frame (start first).
    task automatic send_check(input int inst, input logic [10:0] seq, input int nbits,
                              input string tag, output int waited);
        logic [3:0] got;
        logic       rd_seen;
        waited = 0;
        while (w_rd[inst] !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_fetch"}, {31'd0, w_rd[inst]}, 32'd1);
        if (w_rd[inst] !== 1'b1) return;
        chk({tag, "_fetch_tx"}, {31'd0, w_tx[inst]}, 32'd1);
        @(negedge clk);
        chk({tag, "_latch"}, {w_rd[inst], w_tx[inst], w_busy[inst]}, 3'b011);
        rd_seen = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            got = '0;
            for (int s = 0; s < CPB; s++) begin
                @(negedge clk);
                got[s]  = w_tx[inst];
                rd_seen = rd_seen | w_rd[inst];
            end
            chk($sformatf("%s_bit%0d", tag, b), got, {4{seq[b]}});
        end
        @(negedge clk);
        chk({tag, "_end"}, {w_tx[inst], w_busy[inst], rd_seen}, 3'b100);
    endtask

    initial begin
        int         wt;
        logic [7:0] v;
        rst_n = 1'b0;
        fq_a.push_back(8'hA5);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_hold", {w_tx[0], w_rd[0], w_busy[0], if_a.frame_count}, 7'b100_0000);
        end
        chk("rst_no_read", n_pulse[0], 0);
        rst_n = 1'b1;

        send_check(0, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5", wt);
        chk("a5_count", {28'd0, if_a.frame_count}, 1);
        chk("a5_pulses", n_pulse[0], 1);

        fq_a.push_back(8'h00);
        fq_a.push_back(8'hFF);
        send_check(0, {1'b0, 1'b1, 8'h00, 1'b0}, 10, "b2b0", wt);
        send_check(0, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, "b2b1", wt);
        chk("b2b_gap", wt, 1);
        chk("b2b_count", {28'd0, if_a.frame_count}, 3);
        chk("b2b_pulses", n_pulse[0], 3);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        fq_b.push_back(8'h07);
        send_check(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "even07", wt);
        chk("even_count", {16'd0, if_b.frame_count}, 1);
        fq_c.push_back(8'h07);
        send_check(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, "odd07", wt);
        chk("odd_count", {16'd0, if_c.frame_count}, 1);

        // Reset during data bit 3 of 0x35 (bit 3 is 0, so tx must jump high).
        fq_a.push_back(8'h35);
        fq_a.push_back(8'h5A);
        wt = 0;
        while (w_rd[0] !== 1'b1 && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        chk("mid_fetch", {31'd0, w_rd[0]}, 1);
        repeat (19) @(negedge clk);
        chk("mid_pre", {w_tx[0], w_busy[0]}, 2'b01);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst", {w_tx[0], w_busy[0], if_a.frame_count}, 6'b10_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_check(0, {1'b0, 1'b1, 8'h5A, 1'b0}, 10, "after_rst", wt);
        chk("after_rst_count", {28'd0, if_a.frame_count}, 1);
        chk("after_rst_pulses", n_pulse[0], 5);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            v = 8'(i * 29);
            fq_a.push_back(v);
            send_check(0, {1'b0, 1'b1, v, 1'b0}, 10, $sformatf("wrap%0d", i), wt);
            if (i == 15) chk("wrap_15", {28'd0, if_a.frame_count}, 15);
            if (i == 16) chk("wrap_16", {28'd0, if_a.frame_count}, 0);
            if (i == 17) chk("wrap_17", {28'd0, if_a.frame_count}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
